// File: rtl/aes128_iter_core.sv
// Iterative AES-128 encryptor, UNROLL rounds per clock, key schedule expanded on the fly.
// Optional block counter output enabled by defining AES128_ITER_BLKCNT_EN.
module aes128_iter_core #(
   parameter int UNROLL = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_block,
   input  logic [127:0] in_key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_block,
   output logic         busy
`ifdef AES128_ITER_BLKCNT_EN
   ,
   output logic [31:0]  blk_count
`endif
);

   localparam int N_ITER = 10 / UNROLL;
   localparam logic [3:0] LAST_RND = 4'(11 - UNROLL);

   generate
      if (UNROLL < 1 || UNROLL > 10 || N_ITER * UNROLL != 10) begin : g_bad_unroll
         $error("aes128_iter_core: UNROLL must be 1, 2, 5 or 10");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t       state_reg, state_next;
   logic [127:0] st_reg, key_reg;
   logic [3:0]   rnd_reg;
   logic [127:0] st_next, key_next, sr_next;
   logic [3:0]   rnd_next;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, t;
      p = 8'h00;
      t = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ t;
         t = xtime(t);
      end
      return p;
   endfunction

   // S-box computed as GF(2^8) inverse (x^254) followed by the affine map.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] sq, inv;
      sq  = x;
      inv = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = gmul(sq, sq);
         inv = gmul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   // Byte k of the block is at [127-8k -: 8]; row = k%4, column = k/4.
   function automatic logic [127:0] sub_shift(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
      end
      return o;
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] r);
      case (r)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] t, w0, w1, w2, w3;
      t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
      w0 = k[127:96] ^ t;
      w1 = k[95:64] ^ w0;
      w2 = k[63:32] ^ w1;
      w3 = k[31:0] ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   // UNROLL chained rounds starting at rnd_reg; only meaningful while in RUN.
   always_comb begin
      st_next  = st_reg;
      key_next = key_reg;
      sr_next  = '0;
      rnd_next = rnd_reg;
      for (int i = 0; i < UNROLL; i++) begin
         rnd_next = rnd_reg + 4'(i);
         key_next = next_key(key_next, rcon(rnd_next));
         sr_next  = sub_shift(st_next);
         st_next  = ((rnd_next == 4'd10) ? sr_next : mix_columns(sr_next)) ^ key_next;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (in_valid) state_next = RUN;
         RUN:     if (rnd_reg == LAST_RND) state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      case (state_reg)
         IDLE:    begin in_ready = 1'b1; busy = 1'b0; end
         DONE:    out_valid = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         st_reg    <= '0;
         key_reg   <= '0;
         rnd_reg   <= '0;
         out_block <= '0;
      end else begin
         case (state_reg)
            IDLE: if (in_valid) begin
               st_reg  <= in_block ^ in_key;
               key_reg <= in_key;
               rnd_reg <= 4'd1;
            end
            RUN: begin
               st_reg  <= st_next;
               key_reg <= key_next;
               rnd_reg <= rnd_reg + 4'(UNROLL);
               if (rnd_reg == LAST_RND) out_block <= st_next;
            end
            default: ;
         endcase
      end
   end

`ifdef AES128_ITER_BLKCNT_EN
   always_ff @(posedge clk) begin
      if (reset)
         blk_count <= '0;
      else if (state_reg == DONE && out_ready && blk_count != 32'hffff_ffff)
         blk_count <= blk_count + 32'd1;
   end
`endif

endmodule

// File: tb/tb_aes128_iter_core.sv
// Directed bench for aes128_iter_core: four instances (UNROLL 1/2/5/10), scoreboarded outputs.
module tb_aes128_iter_core;

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

   logic         clk;
   logic         reset;
   logic         in_valid_a  [4];
   logic         in_ready_a  [4];
   logic [127:0] in_block_a  [4];
   logic [127:0] in_key_a    [4];
   logic         out_valid_a [4];
   logic         out_ready_a [4];
   logic [127:0] out_block_a [4];
   logic         busy_a      [4];
`ifdef AES128_ITER_BLKCNT_EN
   logic [31:0]  blk_count_a [4];
`endif

   int n_tests = 0;
   int n_fail  = 0;
   logic [127:0] sb_q[$];

   for (genvar gi = 0; gi < 4; gi++) begin : g_dut
      localparam int UL = (gi == 0) ? 1 : (gi == 1) ? 2 : (gi == 2) ? 5 : 10;
      aes128_iter_core #(.UNROLL(UL)) dut (
         .clk       (clk),
         .reset     (reset),
         .in_valid  (in_valid_a[gi]),
         .in_ready  (in_ready_a[gi]),
         .in_block  (in_block_a[gi]),
         .in_key    (in_key_a[gi]),
         .out_valid (out_valid_a[gi]),
         .out_ready (out_ready_a[gi]),
         .out_block (out_block_a[gi]),
         .busy      (busy_a[gi])
`ifdef AES128_ITER_BLKCNT_EN
         ,
         .blk_count (blk_count_a[gi])
`endif
      );
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Pops the expected ciphertext for instance idx and compares it with out_block.
   task automatic sb_check(input int idx, input string tag);
      logic [127:0] exp;
      n_tests++;
      assert (sb_q.size() > 0) else begin
         n_fail++;
         $error("FAIL %s queue: observed empty required entry", tag);
      end
      exp = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
      check({tag, " block"}, out_block_a[idx], exp);
   endtask

   // One block through instance idx with out_ready high; checks latency, data, release.
   task automatic run_block(input int idx, input logic [127:0] pt, input logic [127:0] key,
                            input logic [127:0] exp, input int lat, input bit scramble,
                            input string tag);
      int k;
      @(negedge clk);
      in_block_a[idx] = pt;
      in_key_a[idx]   = key;
      in_valid_a[idx] = 1'b1;
      k = 0;
      while (!in_ready_a[idx] && k < 50) begin
         @(negedge clk);
         k++;
      end
      sb_q.push_back(exp);
      @(negedge clk);
      in_valid_a[idx] = 1'b0;
      check({tag, " busy"}, busy_a[idx], 1'b1);
      k = 0;
      while (!out_valid_a[idx] && k < 50) begin
         if (scramble) begin
            in_block_a[idx] = {$urandom, $urandom, $urandom, $urandom};
            in_key_a[idx]   = {$urandom, $urandom, $urandom, $urandom};
            in_valid_a[idx] = 1'($urandom);
         end
         @(negedge clk);
         k++;
      end
      in_valid_a[idx] = 1'b0;
      check({tag, " latency"}, 128'(k), 128'(lat));
      sb_check(idx, tag);
      @(negedge clk);
      check({tag, " out_valid drop"}, out_valid_a[idx], 1'b0);
      check({tag, " in_ready back"}, in_ready_a[idx], 1'b1);
   endtask

   initial begin
      int k;
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid_a[i]  = 1'b0;
         in_block_a[i]  = '0;
         in_key_a[i]    = '0;
         out_ready_a[i] = 1'b1;
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check("reset in_ready", in_ready_a[0], 1'b1);
      check("reset out_valid", out_valid_a[0], 1'b0);
      check("reset busy", busy_a[0], 1'b0);
      check("reset out_block", out_block_a[0], '0);

      run_block(0, C1_PT, C1_KEY, C1_CT, 10, 1'b0, "c1 u1");
      run_block(0, B_PT, B_KEY, B_CT, 10, 1'b0, "b u1");
      run_block(1, B_PT, B_KEY, B_CT, 5, 1'b0, "b u2");
      run_block(2, B_PT, B_KEY, B_CT, 2, 1'b0, "b u5");
      run_block(3, B_PT, B_KEY, B_CT, 1, 1'b0, "b u10");

      // Backpressure: hold the zero-vector result while a new request knocks.
      out_ready_a[0] = 1'b0;
      @(negedge clk);
      in_block_a[0] = '0;
      in_key_a[0]   = '0;
      in_valid_a[0] = 1'b1;
      sb_q.push_back(Z_CT);
      @(negedge clk);
      in_block_a[0] = C1_PT;
      in_key_a[0]   = C1_KEY;
      k = 0;
      while (!out_valid_a[0] && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("bp latency", 128'(k), 128'(10));
      sb_check(0, "bp");
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("bp hold valid", out_valid_a[0], 1'b1);
         check("bp hold block", out_block_a[0], Z_CT);
         check("bp in_ready", in_ready_a[0], 1'b0);
      end
      in_valid_a[0]  = 1'b0;
      out_ready_a[0] = 1'b1;
      @(negedge clk);
      check("bp release valid", out_valid_a[0], 1'b0);
      check("bp release in_ready", in_ready_a[0], 1'b1);
      check("bp block kept", out_block_a[0], Z_CT);
      @(negedge clk);
      check("bp single handshake", out_valid_a[0], 1'b0);
      check("bp no accept", busy_a[0], 1'b0);

      run_block(0, B_PT, B_KEY, B_CT, 10, 1'b1, "stable");

      // Reset sampled at the fourth RUN edge discards the block in flight.
      @(negedge clk);
      in_block_a[0] = C1_PT;
      in_key_a[0]   = C1_KEY;
      in_valid_a[0] = 1'b1;
      @(negedge clk);
      in_valid_a[0] = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("rst in_ready", in_ready_a[0], 1'b1);
      check("rst out_valid", out_valid_a[0], 1'b0);
      check("rst busy", busy_a[0], 1'b0);
      check("rst out_block", out_block_a[0], '0);
`ifdef AES128_ITER_BLKCNT_EN
      check("rst blk_count", 128'(blk_count_a[0]), '0);
`endif
      run_block(0, C1_PT, C1_KEY, C1_CT, 10, 1'b0, "c1 after rst");

`ifdef AES128_ITER_BLKCNT_EN
      run_block(0, '0, '0, Z_CT, 10, 1'b0, "cnt blk2");
      run_block(0, B_PT, B_KEY, B_CT, 10, 1'b0, "cnt blk3");
      check("blk_count 3", 128'(blk_count_a[0]), 128'(3));
      @(negedge clk);
      force g_dut[0].dut.blk_count = 32'hffff_ffff;
      @(negedge clk);
      release g_dut[0].dut.blk_count;
      run_block(0, C1_PT, C1_KEY, C1_CT, 10, 1'b0, "cnt sat");
      check("blk_count saturate", 128'(blk_count_a[0]), 128'(32'hffff_ffff));
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("blk_count cleared", 128'(blk_count_a[0]), '0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
